// File: rtl/dram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// dram_cmd_arbiter
//
// Two-requester command scheduler sitting in front of the DRAM controller
// command port. Each cycle at most one requester is granted; the granted
// write/read is presented to the controller one cycle later. Reads are
// remembered in an in-order tag FIFO so the read return can be steered back
// to whichever requester issued it.
//
// Ports
//   clk              system clock, all logic on the rising edge
//   power_on_rst     synchronous active-high reset
//   req0_*/req1_*    requester command streams (valid/cmd/wdata in, ready out)
//   ba_cmd_pm        per-bank "controller can accept" mask
//   command          registered command to the controller
//   write_data       registered write data (0 for reads and idle cycles)
//   valid            registered command strobe
//   read_data        controller read return data
//   read_data_valid  controller read return strobe
//   rsp_data         registered steered read data
//   rsp0_valid       rsp_data belongs to requester 0
//   rsp1_valid       rsp_data belongs to requester 1
//   rd_outstanding   tag FIFO occupancy (0..TAG_DEPTH)
//   err_pulse        one-cycle pulse: dropped reserved/bad-bank command or
//                    orphan read return
// -----------------------------------------------------------------------------
module dram_cmd_arbiter #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned CMD_W     = 36,
    parameter int unsigned NUM_BANK  = 4,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                clk,
    input  logic                power_on_rst,
    input  logic                req0_valid,
    input  logic [CMD_W-1:0]    req0_cmd,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [CMD_W-1:0]    req1_cmd,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                req1_ready,
    input  logic [NUM_BANK-1:0] ba_cmd_pm,
    output logic [CMD_W-1:0]    command,
    output logic [DATA_W-1:0]   write_data,
    output logic                valid,
    input  logic [DATA_W-1:0]   read_data,
    input  logic                read_data_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    output logic [4:0]          rd_outstanding,
    output logic                err_pulse
);

    localparam int unsigned PTR_W   = $clog2(TAG_DEPTH);
    localparam logic [4:0]  DEPTH_C = 5'(TAG_DEPTH);

    localparam logic [1:0] RW_WRITE = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_NOP   = 2'b10;
    localparam logic [1:0] RW_RSVD  = 2'b11;

    // Bank field is 3 bits but only NUM_BANK banks exist.
    function automatic logic bank_ok_f(input logic [2:0] b);
        return ({29'd0, b} < NUM_BANK);
    endfunction

    // Mask lookup widened to the full 3-bit bank range; missing banks read 0.
    function automatic logic pm_bit_f(input logic [NUM_BANK-1:0] pm, input logic [2:0] b);
        logic [7:0] ext;
        ext = 8'(pm);
        return ext[b];
    endfunction

    // A requester may be granted when its command can be consumed this cycle.
    // Bad-bank and NOP/reserved commands are always consumable (they get dropped).
    function automatic logic elig_f(input logic                vld,
                                    input logic [CMD_W-1:0]    cmd,
                                    input logic [NUM_BANK-1:0] pm,
                                    input logic                tag_full);
        logic       e;
        logic [2:0] b;
        b = cmd[2:0];
        case (cmd[32:31])
            RW_WRITE: e = !bank_ok_f(b) || pm_bit_f(pm, b);
            RW_READ:  e = !bank_ok_f(b) || (pm_bit_f(pm, b) && !tag_full);
            RW_NOP:   e = 1'b1;
            RW_RSVD:  e = 1'b1;
            default:  e = 1'b1;
        endcase
        return vld && e;
    endfunction

    // State
    logic                last_r;          // 1: requester 1 was granted most recently
    logic [CMD_W-1:0]    command_r;
    logic [DATA_W-1:0]   write_data_r;
    logic                valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp0_valid_r;
    logic                rsp1_valid_r;
    logic                err_r;
    logic [4:0]          occ_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic                tag_mem_r [TAG_DEPTH];

    // Combinational
    logic                tag_full_s;
    logic                elig0_s;
    logic                elig1_s;
    logic                grant0_s;
    logic                grant1_s;
    logic                any_grant_s;
    logic [CMD_W-1:0]    sel_cmd_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_id_s;
    logic [1:0]          sel_rw_s;
    logic                sel_bank_ok_s;
    logic                issue_s;
    logic                push_s;
    logic                drop_err_s;
    logic                pop_s;
    logic                orphan_s;

    // Fullness uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign tag_full_s = (occ_r >= DEPTH_C);
    assign elig0_s    = elig_f(req0_valid, req0_cmd, ba_cmd_pm, tag_full_s);
    assign elig1_s    = elig_f(req1_valid, req1_cmd, ba_cmd_pm, tag_full_s);

    // Round-robin grant between eligible requesters; nothing is consumed in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (power_on_rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (elig0_s && elig1_s) begin
            if (last_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (elig0_s) begin
            grant0_s = 1'b1;
        end else if (elig1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign any_grant_s = grant0_s || grant1_s;

    // Select the granted requester's command, data and id.
    always_comb begin
        sel_cmd_s   = '0;
        sel_wdata_s = '0;
        sel_id_s    = 1'b0;
        if (grant1_s) begin
            sel_cmd_s   = req1_cmd;
            sel_wdata_s = req1_wdata;
            sel_id_s    = 1'b1;
        end else if (grant0_s) begin
            sel_cmd_s   = req0_cmd;
            sel_wdata_s = req0_wdata;
            sel_id_s    = 1'b0;
        end else begin
            sel_cmd_s   = '0;
            sel_wdata_s = '0;
            sel_id_s    = 1'b0;
        end
    end

    assign sel_rw_s      = sel_cmd_s[32:31];
    assign sel_bank_ok_s = bank_ok_f(sel_cmd_s[2:0]);

    // Classify what the granted command does: issue, drop with error, or vanish (NOP).
    always_comb begin
        issue_s    = 1'b0;
        push_s     = 1'b0;
        drop_err_s = 1'b0;
        if (any_grant_s) begin
            case (sel_rw_s)
                RW_WRITE: begin
                    issue_s    = sel_bank_ok_s;
                    drop_err_s = !sel_bank_ok_s;
                end
                RW_READ: begin
                    issue_s    = sel_bank_ok_s;
                    push_s     = sel_bank_ok_s;
                    drop_err_s = !sel_bank_ok_s;
                end
                RW_NOP: begin
                    issue_s    = 1'b0;
                end
                RW_RSVD: begin
                    drop_err_s = 1'b1;
                end
                default: begin
                    drop_err_s = 1'b1;
                end
            endcase
        end else begin
            issue_s    = 1'b0;
            push_s     = 1'b0;
            drop_err_s = 1'b0;
        end
    end

    // A return pops only against reads already stored; a same-cycle push cannot match it.
    assign pop_s    = read_data_valid && (occ_r != 5'd0);
    assign orphan_s = read_data_valid && (occ_r == 5'd0);

    // Round-robin pointer: moves only when someone is granted.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            last_r <= 1'b1;
        end else if (any_grant_s) begin
            last_r <= sel_id_s;
        end
    end

    // Command port register: one-cycle issue pulse, zero otherwise.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            command_r    <= '0;
            write_data_r <= '0;
            valid_r      <= 1'b0;
        end else if (issue_s) begin
            command_r    <= sel_cmd_s;
            write_data_r <= (sel_rw_s == RW_WRITE) ? sel_wdata_s : '0;
            valid_r      <= 1'b1;
        end else begin
            command_r    <= '0;
            write_data_r <= '0;
            valid_r      <= 1'b0;
        end
    end

    // Tag storage: requester id of each issued read, in issue order.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= sel_id_s;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= 5'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 5'd1;
                2'b01:   occ_r <= occ_r - 5'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Response steering: data and owner flag one cycle after the return.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            rsp_data_r   <= '0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else if (pop_s) begin
            rsp_data_r   <= read_data;
            rsp0_valid_r <= !tag_mem_r[rd_ptr_r];
            rsp1_valid_r <= tag_mem_r[rd_ptr_r];
        end else begin
            rsp_data_r   <= '0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end
    end

    // Error pulse: dropped command or orphan return in the previous cycle.
    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= drop_err_s || orphan_s;
        end
    end

    assign req0_ready     = grant0_s;
    assign req1_ready     = grant1_s;
    assign command        = command_r;
    assign write_data     = write_data_r;
    assign valid          = valid_r;
    assign rsp_data       = rsp_data_r;
    assign rsp0_valid     = rsp0_valid_r;
    assign rsp1_valid     = rsp1_valid_r;
    assign rd_outstanding = occ_r;
    assign err_pulse      = err_r;

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_cmd_arbiter
//
// Directed stimulus for dram_cmd_arbiter. A behavioural model (queue of
// requester ids, round-robin owner, expected registered outputs) is advanced
// once per cycle and compared against the DUT on every falling edge; a set of
// hand-computed literal checks inside the stimulus pins the model itself.
// Inputs change only 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_dram_cmd_arbiter;

    localparam int DATA_W = 128;
    localparam int CMD_W  = 36;

    logic              clk;
    logic              power_on_rst;
    logic              req0_valid;
    logic [CMD_W-1:0]  req0_cmd;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req1_valid;
    logic [CMD_W-1:0]  req1_cmd;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic [3:0]        ba_cmd_pm;
    logic [CMD_W-1:0]  command;
    logic [DATA_W-1:0] write_data;
    logic              valid;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [4:0]        rd_outstanding;
    logic              err_pulse;

    int checks   = 0;
    int failures = 0;

    dram_cmd_arbiter dut (
        .clk             (clk),
        .power_on_rst    (power_on_rst),
        .req0_valid      (req0_valid),
        .req0_cmd        (req0_cmd),
        .req0_wdata      (req0_wdata),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_cmd        (req1_cmd),
        .req1_wdata      (req1_wdata),
        .req1_ready      (req1_ready),
        .ba_cmd_pm       (ba_cmd_pm),
        .command         (command),
        .write_data      (write_data),
        .valid           (valid),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .rsp_data        (rsp_data),
        .rsp0_valid      (rsp0_valid),
        .rsp1_valid      (rsp1_valid),
        .rd_outstanding  (rd_outstanding),
        .err_pulse       (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] rw, input logic [2:0] bank,
                                                input logic [12:0] row, input logic [9:0] col);
        return {3'd0, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                m_q[$];      // requester id of each outstanding read, oldest first
    int                m_last = 1;
    bit                chk_en = 1'b0;
    logic [CMD_W-1:0]  e_cmd  = '0;
    logic [DATA_W-1:0] e_wd   = '0;
    logic [DATA_W-1:0] e_rsp  = '0;
    bit                e_valid = 1'b0;
    bit                e_r0 = 1'b0;
    bit                e_r1 = 1'b0;
    bit                e_err = 1'b0;

    function automatic bit m_elig(input logic vld, input logic [CMD_W-1:0] cmd);
        int rw;
        int b;
        rw = int'(cmd[32:31]);
        b  = int'(cmd[2:0]);
        if (!vld) return 1'b0;
        if (rw >= 2 || b >= 4) return 1'b1;
        if (rw == 1 && m_q.size() >= 16) return 1'b0;
        return ba_cmd_pm[b];
    endfunction

    initial begin
        forever begin
            bit               e0;
            bit               e1;
            int               winner;
            int               pushed;
            int               rw;
            int               b;
            logic [CMD_W-1:0] gc;
            @(negedge clk);
            winner = -1;
            if (!power_on_rst) begin
                e0 = m_elig(req0_valid, req0_cmd);
                e1 = m_elig(req1_valid, req1_cmd);
                if (e0 && e1)  winner = 1 - m_last;
                else if (e0)   winner = 0;
                else if (e1)   winner = 1;
            end
            if (chk_en) begin
                check("m_ready0", req0_ready, winner == 0);
                check("m_ready1", req1_ready, winner == 1);
                check("m_valid", valid, e_valid);
                check("m_command", command, e_cmd);
                check("m_wdata", write_data, e_wd);
                check("m_rsp0", rsp0_valid, e_r0);
                check("m_rsp1", rsp1_valid, e_r1);
                check("m_rsp_data", rsp_data, e_rsp);
                check("m_outst", rd_outstanding, m_q.size());
                check("m_err", err_pulse, e_err);
            end
            e_valid = 0; e_cmd = '0; e_wd = '0; e_rsp = '0; e_r0 = 0; e_r1 = 0; e_err = 0;
            if (power_on_rst) begin
                m_q.delete();
                m_last = 1;
                chk_en = 1'b1;
            end else begin
                pushed = -1;
                if (winner >= 0) begin
                    gc = (winner == 0) ? req0_cmd : req1_cmd;
                    rw = int'(gc[32:31]);
                    b  = int'(gc[2:0]);
                    if (rw == 3 || (rw < 2 && b >= 4)) begin
                        e_err = 1;
                    end else if (rw < 2) begin
                        e_valid = 1;
                        e_cmd   = gc;
                        e_wd    = (rw == 0) ? ((winner == 0) ? req0_wdata : req1_wdata) : '0;
                        if (rw == 1) pushed = winner;
                    end
                    m_last = winner;
                end
                if (read_data_valid) begin
                    if (m_q.size() > 0) begin
                        if (m_q.pop_front()) e_r1 = 1; else e_r0 = 1;
                        e_rsp = read_data;
                    end else begin
                        e_err = 1;
                    end
                end
                if (pushed >= 0) m_q.push_back(pushed[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; read_data_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        power_on_rst = 1;
        tick();
        power_on_rst = 0;
    endtask

    logic [CMD_W-1:0] c_w0;

    initial begin
        power_on_rst = 1; idle_inputs();
        req0_cmd = '0; req1_cmd = '0; req0_wdata = '0; req1_wdata = '0;
        ba_cmd_pm = 4'h0; read_data = '0;
        tick(); tick();
        power_on_rst = 0;

        // Test 1: single write to bank 0
        c_w0 = mk_cmd(2'b00, 3'd0, 13'h5, 10'h10);
        ba_cmd_pm = 4'b0001; req0_valid = 1; req0_cmd = c_w0; req0_wdata = 128'hA5;
        @(negedge clk);
        check("t1_ready0", req0_ready, 1'b1);
        check("t1_reset_valid", valid, 1'b0);
        tick(); req0_valid = 0;
        @(negedge clk);
        check("t1_valid", valid, 1'b1);
        check("t1_cmd", command, c_w0);
        check("t1_wdata", write_data, 128'hA5);
        check("t1_outst", rd_outstanding, 5'd0);
        tick();

        // Test 2: alternating reads from both requesters, in-order returns
        do_reset();
        ba_cmd_pm = 4'hF;
        req0_valid = 1; req0_cmd = mk_cmd(2'b01, 3'd1, 13'h1, 10'h0);
        req1_valid = 1; req1_cmd = mk_cmd(2'b01, 3'd1, 13'h2, 10'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2_grant0", req0_ready, (i % 2) == 0);
            check("t2_grant1", req1_ready, (i % 2) == 1);
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("t2_outst", rd_outstanding, 5'd6);
        tick();
        for (int i = 0; i < 6; i++) begin
            read_data_valid = 1; read_data = 128'h100 + 128'(i);
            tick();
            read_data_valid = 0;
            @(negedge clk);
            check("t2_rsp0", rsp0_valid, (i % 2) == 0);
            check("t2_rsp1", rsp1_valid, (i % 2) == 1);
            check("t2_rsp_data", rsp_data, 128'h100 + 128'(i));
            tick();
        end

        // Test 3: blocked bank does not block the other requester
        do_reset();
        ba_cmd_pm = 4'b1000;
        req0_valid = 1; req0_cmd = mk_cmd(2'b00, 3'd2, 13'h3, 10'h4); req0_wdata = 128'h22;
        req1_valid = 1; req1_cmd = mk_cmd(2'b00, 3'd3, 13'h3, 10'h8); req1_wdata = 128'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall0", req0_ready, 1'b0);
            check("t3_go1", req1_ready, 1'b1);
            tick();
        end
        ba_cmd_pm = 4'b1100;
        @(negedge clk);
        check("t3_unblock0", req0_ready, 1'b1);
        check("t3_wait1", req1_ready, 1'b0);
        tick(); idle_inputs();

        // Test 4: tag FIFO full stalls reads but not writes
        do_reset();
        ba_cmd_pm = 4'hF;
        req0_valid = 1; req0_cmd = mk_cmd(2'b01, 3'd0, 13'h7, 10'h0);
        repeat (16) tick();
        @(negedge clk);
        check("t4_full", rd_outstanding, 5'd16);
        check("t4_stall", req0_ready, 1'b0);
        tick();
        req1_valid = 1; req1_cmd = mk_cmd(2'b00, 3'd1, 13'h7, 10'h1); req1_wdata = 128'h44;
        read_data_valid = 1; read_data = 128'h77;
        @(negedge clk);
        check("t4_rd_still_stalled", req0_ready, 1'b0);
        check("t4_write_goes", req1_ready, 1'b1);
        tick();
        read_data_valid = 0; req1_valid = 0;
        @(negedge clk);
        check("t4_resume", req0_ready, 1'b1);
        check("t4_outst15", rd_outstanding, 5'd15);
        tick(); idle_inputs();

        // Test 5: reserved, bad bank, NOP
        do_reset();
        ba_cmd_pm = 4'hF;
        req0_valid = 1; req0_cmd = mk_cmd(2'b11, 3'd0, 13'h0, 10'h0);
        @(negedge clk);
        check("t5_rsvd_ready", req0_ready, 1'b1);
        tick();
        req0_cmd = mk_cmd(2'b00, 3'd5, 13'h0, 10'h0);
        @(negedge clk);
        check("t5_bank_ready", req0_ready, 1'b1);
        check("t5_rsvd_err", err_pulse, 1'b1);
        check("t5_rsvd_valid", valid, 1'b0);
        tick();
        req0_cmd = mk_cmd(2'b10, 3'd0, 13'h0, 10'h0);
        @(negedge clk);
        check("t5_nop_ready", req0_ready, 1'b1);
        check("t5_bank_err", err_pulse, 1'b1);
        check("t5_bank_valid", valid, 1'b0);
        tick(); req0_valid = 0;
        @(negedge clk);
        check("t5_nop_err", err_pulse, 1'b0);
        check("t5_nop_valid", valid, 1'b0);
        tick();

        // Test 6: reset with reads outstanding, then orphan return (with a same-cycle push)
        do_reset();
        ba_cmd_pm = 4'hF;
        req0_valid = 1; req0_cmd = mk_cmd(2'b01, 3'd0, 13'h9, 10'h0);
        repeat (3) tick();
        req0_valid = 0; power_on_rst = 1;
        tick();
        power_on_rst = 0;
        req0_valid = 1; read_data_valid = 1; read_data = 128'h55;
        @(negedge clk);
        check("t6_outst_rst", rd_outstanding, 5'd0);
        check("t6_valid_rst", valid, 1'b0);
        check("t6_err_rst", err_pulse, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t6_orphan_err", err_pulse, 1'b1);
        check("t6_orphan_rsp0", rsp0_valid, 1'b0);
        check("t6_orphan_rsp1", rsp1_valid, 1'b0);
        check("t6_push_kept", rd_outstanding, 5'd1);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
